// File: rtl/module_seg_scan.sv
// Multiplexed 7-segment display driver.
// Scans N_DIG hex digits one slot at a time, blanking every anode and segment
// for the first BLANK_CYCLES of each slot so that the previous digit's pattern
// never ghosts onto the next anode. New content is captured into a pending
// register and copied to the displayed (shadow) register only at a frame
// boundary, so every digit of a frame comes from the same snapshot.
//
// Timing: all outputs are registered. The value seen after edge t+1 reflects
// cnt, idx, shadow and blank_i as they were at edge t (one-cycle latency).
module module_seg_scan #(
    parameter int DIGIT_CYCLES = 27000,
    parameter int BLANK_CYCLES = 64,
    parameter int N_DIG        = 2,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*N_DIG-1:0]   data_i,
    input  logic                 load_i,
    input  logic [N_DIG-1:0]     blank_i,
    output logic [6:0]           seg_o,
    output logic [N_DIG-1:0]     an_o,
    output logic                 frame_o
);

    // Parameter sanity: the slot must leave some visible time after blanking,
    // and the anode vector is limited to 8 digits.
    generate
        if (BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
            $error("module_seg_scan: BLANK_CYCLES must be smaller than DIGIT_CYCLES");
        end
        if (N_DIG < 1 || N_DIG > 8) begin : g_bad_ndig
            $error("module_seg_scan: N_DIG must be in 1..8");
        end
    endgenerate

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    // Inactive levels for the two output buses.
    localparam logic [6:0]       SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIG-1:0] AN_OFF  = AN_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [3:0]         shadow  [N_DIG];
    logic [3:0]         pending [N_DIG];
    logic               pend;

    logic               slot_end;
    logic               boundary;
    logic               in_blank;
    logic               digit_blanked;
    logic [3:0]         cur_nibble;
    logic [6:0]         hex_seg;
    logic [N_DIG-1:0]   one_hot;
    logic [6:0]         seg_next;
    logic [N_DIG-1:0]   an_next;

    // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Slot/frame position decode and next output pattern for the current slot.
    always_comb begin
        slot_end      = (cnt == CNT_LAST);
        boundary      = slot_end && (idx == IDX_LAST);
        in_blank      = (cnt < CNT_BLANK);
        digit_blanked = blank_i[idx];
        cur_nibble    = shadow[idx];
        hex_seg       = hex_to_seg(cur_nibble);
        one_hot       = '0;
        one_hot[idx]  = 1'b1;

        if (in_blank || digit_blanked) begin
            seg_next = SEG_OFF;
            an_next  = AN_OFF;
        end else begin
            seg_next = SEG_ACT_LOW ? ~hex_seg : hex_seg;
            an_next  = AN_ACT_LOW ? ~one_hot : one_hot;
        end
    end

    // Slot cycle counter and digit index; idx advances when a slot wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Display content: loads go to pending mid-frame; at the boundary the
    // shadow takes either a coincident load directly or the pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            for (int k = 0; k < N_DIG; k++) begin
                shadow[k]  <= 4'h0;
                pending[k] <= 4'h0;
            end
        end else if (boundary) begin
            pend <= 1'b0;
            if (load_i) begin
                for (int k = 0; k < N_DIG; k++) begin
                    shadow[k] <= data_i[4*k +: 4];
                end
            end else if (pend) begin
                for (int k = 0; k < N_DIG; k++) begin
                    shadow[k] <= pending[k];
                end
            end
        end else if (load_i) begin
            pend <= 1'b1;
            for (int k = 0; k < N_DIG; k++) begin
                pending[k] <= data_i[4*k +: 4];
            end
        end
    end

    // Registered outputs; frame_o marks the cycle after the shadow update.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o   <= SEG_OFF;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_next;
            an_o    <= an_next;
            frame_o <= boundary;
        end
    end

endmodule

// File: tb/tb_module_seg_scan.sv
// Directed bench for module_seg_scan with 8-cycle slots, 2 blank cycles,
// two digits and active-low segments/anodes. Each frame is checked cycle by
// cycle against an expected queue built from hand-written segment patterns.
module tb_module_seg_scan;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int ND = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic        load_i = 1'b0;
    logic [1:0]  blank_i = 2'b00;
    logic [6:0]  seg_o;
    logic [1:0]  an_o;
    logic        frame_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {frame_o, an_o, seg_o} per cycle of a frame.
    logic [9:0] exp_q[$];

    // Active-low segment patterns {g..a} for hex 0..F.
    logic [6:0] seg_al [16];

    // Clock
    always #5 clk = ~clk;

    module_seg_scan #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .N_DIG        (ND),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .load_i  (load_i),
        .blank_i (blank_i),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs for cycles k=1..16 after a frame start: slot k-1 maps
    // to cnt=(k-1)%8 and digit (k-1)/8; the last cycle carries frame_o.
    task automatic build_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] blank);
        exp_q.delete();
        for (int k = 1; k <= 2 * DC; k++) begin
            int c;
            int d;
            logic       act;
            logic [1:0] an;
            logic [6:0] sg;
            c   = (k - 1) % DC;
            d   = (k - 1) / DC;
            act = (c >= BC) && !blank[d];
            an  = act ? ((d == 0) ? 2'b10 : 2'b01) : 2'b11;
            sg  = act ? seg_al[(d == 0) ? d0 : d1] : 7'h7F;
            exp_q.push_back({(k == 2 * DC), an, sg});
        end
    endtask

    // Run one frame starting right after a frame-start edge, optionally
    // driving up to two loads, driven at cycle lk1/lk2 and captured on the next edge.
    task automatic run_frame(input string name, input logic [3:0] d0, input logic [3:0] d1,
                             input logic [1:0] blank,
                             input int lk1, input logic [7:0] ld1,
                             input int lk2, input logic [7:0] ld2);
        logic [9:0] e;
        build_frame(d0, d1, blank);
        blank_i = blank;
        for (int k = 1; k <= 2 * DC; k++) begin
            @(negedge clk);
            load_i = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("%s_an_k%0d", name, k), 32'(an_o), 32'(e[8:7]));
            check($sformatf("%s_seg_k%0d", name, k), 32'(seg_o), 32'(e[6:0]));
            check($sformatf("%s_frame_k%0d", name, k), 32'(frame_o), 32'(e[9]));
            if (k == lk1) begin
                data_i = ld1;
                load_i = 1'b1;
            end else if (k == lk2) begin
                data_i = ld2;
                load_i = 1'b1;
            end
        end
    endtask

    initial begin
        seg_al[0]  = 7'b1000000; seg_al[1]  = 7'b1111001;
        seg_al[2]  = 7'b0100100; seg_al[3]  = 7'b0110000;
        seg_al[4]  = 7'b0011001; seg_al[5]  = 7'b0010010;
        seg_al[6]  = 7'b0000010; seg_al[7]  = 7'b1111000;
        seg_al[8]  = 7'b0000000; seg_al[9]  = 7'b0010000;
        seg_al[10] = 7'b0001000; seg_al[11] = 7'b0000011;
        seg_al[12] = 7'b1000110; seg_al[13] = 7'b0100001;
        seg_al[14] = 7'b0000110; seg_al[15] = 7'b0001110;

        // Reset held for 3 cycles: everything dark, no frame pulse.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_an_%0d", i), 32'(an_o), 32'h3);
            check($sformatf("rst_seg_%0d", i), 32'(seg_o), 32'h7F);
            check($sformatf("rst_frame_%0d", i), 32'(frame_o), 32'h0);
        end
        rst = 1'b0;

        // First frame after reset shows "00"; digit0 visible from cycle 3.
        run_frame("f1", 4'h0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00);
        // Mid-frame load of 5A is held pending.
        run_frame("f2", 4'h0, 4'h0, 2'b00, 3, 8'h5A, 0, 8'h00);
        // 5A displayed; load 12 during the digit1 slot must not tear.
        run_frame("f3", 4'hA, 4'h5, 2'b00, 11, 8'h12, 0, 8'h00);
        // 12 displayed; two loads, last one wins.
        run_frame("f4", 4'h2, 4'h1, 2'b00, 2, 8'h33, 5, 8'h44);
        // 44 displayed; load F0 captured on the boundary edge.
        run_frame("f5", 4'h4, 4'h4, 2'b00, 15, 8'hF0, 0, 8'h00);
        // F0 displayed immediately; a second load this frame stays pending.
        run_frame("f6", 4'h0, 4'hF, 2'b00, 4, 8'h77, 0, 8'h00);
        // 77 displayed with digit1 blanked.
        run_frame("f7", 4'h7, 4'h7, 2'b10, 0, 8'h00, 0, 8'h00);

        // Reset in the middle of the digit0 slot.
        blank_i = 2'b00;
        repeat (4) @(negedge clk);
        check("pre_rst_an", 32'(an_o), 32'h2);
        check("pre_rst_seg", 32'(seg_o), 32'(seg_al[7]));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_an", 32'(an_o), 32'h3);
        check("mid_rst_seg", 32'(seg_o), 32'h7F);
        check("mid_rst_frame", 32'(frame_o), 32'h0);
        rst = 1'b0;
        // Scanning restarts at digit 0 with a cleared shadow.
        run_frame("f8", 4'h0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
